// File: rtl/proc_mc_pkg.sv
// Shared types and instruction field positions for the proc_mc processor.
// The PROC_MC_MUL_EN build option adds OP_MUL to the executed opcode set.
package proc_mc_pkg;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_HALT  = 3'd4
    } e_state;

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_OUTI   = 4'h1,
        OP_OUTLOC = 4'h2,
        OP_LI     = 4'h3,
        OP_OUTR   = 4'h4,
        OP_LD     = 4'h5,
        OP_ST     = 4'h6,
        OP_ADDI   = 4'h7,
        OP_BNZ    = 4'h8,
        OP_MUL    = 4'h9,
        OP_HALT   = 4'hF
    } e_op;

    localparam int REG_MSB = 15;
    localparam int REG_LSB = 12;
    localparam int OP_MSB  = 11;
    localparam int OP_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

endpackage

// File: rtl/proc_mc_regfile.sv
// NUM_REGS x DATA_W register file: combinational read, synchronous write, async clear.
// With PROC_MC_MUL_EN defined a second read port feeds the multiplier.
module proc_mc_regfile #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int RA_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RA_W-1:0]   rd_addr,
    output logic [DATA_W-1:0] rd_data,
`ifdef PROC_MC_MUL_EN
    input  logic [RA_W-1:0]   rd2_addr,
    output logic [DATA_W-1:0] rd2_data,
`endif
    input  logic              we,
    input  logic [RA_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] x1
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // next register contents: single write port
    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[wr_addr] = wr_data;
        end else begin
            regs_d[wr_addr] = regs_q[wr_addr];
        end
    end

    // register storage with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_data = regs_q[rd_addr];
`ifdef PROC_MC_MUL_EN
    assign rd2_data = regs_q[rd2_addr];
`endif
    assign x1 = regs_q[1];

endmodule

// File: rtl/proc_mc.sv
// Multi-cycle processor: FETCH/EXEC/MEM over a req/ack unified memory port.
// Define PROC_MC_MUL_EN to execute op 9 (MUL); otherwise op 9 halts as illegal.
module proc_mc
    import proc_mc_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out,
    output logic              outen,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        state,
    output logic              halted,
    output logic              illegal,
    output logic [DATA_W-1:0] x1
);

    localparam int RA_W = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    e_state            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, maddr_q, maddr_d;
    logic [15:0]       instr_q, instr_d;
    logic [DATA_W-1:0] out_q, out_d, mwdata_q, mwdata_d;
    logic              outen_q, outen_d, illegal_q, illegal_d, mwe_q, mwe_d;

    logic [3:0]        rsel_s;
    e_op               op_s;
    logic [7:0]        imm_s;
    logic [DATA_W-1:0] imm_dw_s, rdata_s, rf_wdata_s;
    logic [ADDR_W-1:0] imm_aw_s;
    logic              rf_we_s;

    assign rsel_s   = instr_q[REG_MSB:REG_LSB];
    assign op_s     = e_op'(instr_q[OP_MSB:OP_LSB]);
    assign imm_s    = instr_q[IMM_MSB:IMM_LSB];
    assign imm_dw_s = DATA_W'(imm_s);
    assign imm_aw_s = ADDR_W'(imm_s);

`ifdef PROC_MC_MUL_EN
    logic [DATA_W-1:0] rdata2_s, mul_s;
    assign mul_s = rdata_s * rdata2_s;
`endif

    proc_mc_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .RA_W     (RA_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rsel_s[RA_W-1:0]),
        .rd_data  (rdata_s),
`ifdef PROC_MC_MUL_EN
        .rd2_addr (imm_s[RA_W-1:0]),
        .rd2_data (rdata2_s),
`endif
        .we       (rf_we_s),
        .wr_addr  (rsel_s[RA_W-1:0]),
        .wr_data  (rf_wdata_s),
        .x1       (x1)
    );

    // next-state, datapath updates and register-file write control
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        out_d      = out_q;
        outen_d    = 1'b0;
        illegal_d  = illegal_q;
        maddr_d    = maddr_q;
        mwe_d      = mwe_q;
        mwdata_d   = mwdata_q;
        rf_we_s    = 1'b0;
        rf_wdata_s = '0;
        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem_ack) begin
                    instr_d = mem_rdata[15:0];
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = pc_q + PC_ONE;
                if ({1'b0, rsel_s} >= 5'(NUM_REGS)) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                    pc_d      = pc_q;
                end else begin
                    case (op_s)
                        OP_NOP:  state_d = ST_FETCH;
                        OP_OUTI: begin
                            out_d   = imm_dw_s;
                            outen_d = 1'b1;
                        end
                        // memory ops hold pc until the transfer is acknowledged
                        OP_OUTLOC, OP_LD, OP_ST: begin
                            maddr_d  = imm_aw_s;
                            mwe_d    = (op_s == OP_ST);
                            mwdata_d = rdata_s;
                            pc_d     = pc_q;
                            state_d  = ST_MEM;
                        end
                        OP_LI: begin
                            rf_we_s    = 1'b1;
                            rf_wdata_s = imm_dw_s;
                        end
                        OP_OUTR: begin
                            out_d   = rdata_s;
                            outen_d = 1'b1;
                        end
                        OP_ADDI: begin
                            rf_we_s    = 1'b1;
                            rf_wdata_s = rdata_s + imm_dw_s;
                        end
                        OP_BNZ: begin
                            if (rdata_s != '0) begin
                                pc_d = imm_aw_s;
                            end else begin
                                pc_d = pc_q + PC_ONE;
                            end
                        end
`ifdef PROC_MC_MUL_EN
                        OP_MUL: begin
                            if ({1'b0, imm_s[3:0]} >= 5'(NUM_REGS)) begin
                                illegal_d = 1'b1;
                                state_d   = ST_HALT;
                                pc_d      = pc_q;
                            end else begin
                                rf_we_s    = 1'b1;
                                rf_wdata_s = mul_s;
                            end
                        end
`endif
                        OP_HALT: begin
                            state_d = ST_HALT;
                            pc_d    = pc_q;
                        end
                        default: begin
                            illegal_d = 1'b1;
                            state_d   = ST_HALT;
                            pc_d      = pc_q;
                        end
                    endcase
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    pc_d    = pc_q + PC_ONE;
                    state_d = ST_FETCH;
                    if (op_s == OP_LD) begin
                        rf_we_s    = 1'b1;
                        rf_wdata_s = mem_rdata;
                    end else if (op_s == OP_OUTLOC) begin
                        out_d   = mem_rdata;
                        outen_d = 1'b1;
                    end else begin
                        rf_we_s = 1'b0;
                    end
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RESET;
        endcase
    end

    // architectural and control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RESET;
            pc_q      <= '0;
            instr_q   <= 16'h0000;
            out_q     <= '0;
            outen_q   <= 1'b0;
            illegal_q <= 1'b0;
            maddr_q   <= '0;
            mwe_q     <= 1'b0;
            mwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            out_q     <= out_d;
            outen_q   <= outen_d;
            illegal_q <= illegal_d;
            maddr_q   <= maddr_d;
            mwe_q     <= mwe_d;
            mwdata_q  <= mwdata_d;
        end
    end

    assign mem_req   = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign mem_we    = (state_q == ST_MEM) && mwe_q;
    assign mem_addr  = (state_q == ST_FETCH) ? pc_q :
                       ((state_q == ST_MEM) ? maddr_q : '0);
    assign mem_wdata = (state_q == ST_MEM) ? mwdata_q : '0;
    assign out       = out_q;
    assign outen     = outen_q;
    assign pc        = pc_q;
    assign state     = state_q;
    assign halted    = (state_q == ST_HALT);
    assign illegal   = illegal_q;

endmodule
